ascii_serial_tx: RTL and testbench

//  Serializer that drives 8-bit ASCII characters MSB-first, one bit per bit_tick, onto a single line.
//  It is the source end of the ASCII bit-stream link: strobed bits feed the serial character detectors.

---
 rtl/ascii_serial_tx_pkg.sv | 17 +
 rtl/ascii_serial_tx_if.sv | 35 +++
 rtl/ascii_serial_tx.sv | 111 +++++++++++
 tb/tb_ascii_serial_tx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_serial_tx_pkg.sv
// Shared state encoding and line constants for the ASCII serial transmitter.
package ascii_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } tx_state_e;

  localparam logic [7:0] ASCII_E        = 8'h45;
  localparam logic       ASCII_IDLE_BIT = 1'b1;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ascii_serial_tx_if.sv
// Load/serial-line bundle of the ASCII transmitter; the master loads characters and ticks, the slave serializes.
// Carries char_count only when ASCII_TX_CHAR_COUNT_EN is defined.
interface ascii_serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              bit_tick;
  logic [DATA_W-1:0] char_in;
  logic              load_valid;
  logic              load_ready;
  logic              ser_out;
  logic              ser_strobe;
  logic              busy;
  logic              done;
`ifdef ASCII_TX_CHAR_COUNT_EN
  logic [7:0]        char_count;

  modport master (
    output bit_tick, char_in, load_valid,
    input  load_ready, ser_out, ser_strobe, busy, done, char_count
  );
  modport slave (
    input  bit_tick, char_in, load_valid,
    output load_ready, ser_out, ser_strobe, busy, done, char_count
  );
`else
  modport master (
    output bit_tick, char_in, load_valid,
    input  load_ready, ser_out, ser_strobe, busy, done
  );
  modport slave (
    input  bit_tick, char_in, load_valid,
    output load_ready, ser_out, ser_strobe, busy, done
  );
`endif
endinterface

// File: rtl/ascii_serial_tx.sv
// MSB-first character serializer with optional trailing '1' gap bits, one bit per bit_tick.
// Optional feature macro: ASCII_TX_CHAR_COUNT_EN adds a wrapping 8-bit completed-character counter.
module ascii_serial_tx
  import ascii_serial_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int GAP_BITS = 1
) (
  input  logic        CLOCK_50,
  input  logic        RESET,
  ascii_serial_tx_if.slave bus
);

  localparam int CNT_W = $clog2(max2(DATA_W, GAP_BITS) + 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ser_out_q, ser_out_d;
  logic              strobe_q, strobe_d;
  logic              done_q, done_d;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      ser_out_q <= ASCII_IDLE_BIT;
      strobe_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      ser_out_q <= ser_out_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    ser_out_d = ser_out_q;
    strobe_d  = 1'b0;
    done_d    = 1'b0;
    unique case (state_q)
      // A tick arriving with the load is dropped: the first bit needs its own tick.
      IDLE: begin
        if (bus.load_valid) begin
          shreg_d = bus.char_in;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.bit_tick) begin
          ser_out_d = shreg_q[DATA_W-1];
          strobe_d  = 1'b1;
          shreg_d   = shreg_q << 1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == DATA_LAST) begin
            cnt_d = '0;
            if (GAP_BITS > 0) begin
              state_d = GAP;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (bus.bit_tick) begin
          ser_out_d = ASCII_IDLE_BIT;
          strobe_d  = 1'b1;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == GAP_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.load_ready = (state_q == IDLE);
  assign bus.busy       = (state_q != IDLE);
  assign bus.ser_out    = ser_out_q;
  assign bus.ser_strobe = strobe_q;
  assign bus.done       = done_q;

`ifdef ASCII_TX_CHAR_COUNT_EN
  logic [7:0] char_count_q;

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      char_count_q <= '0;
    end else if (done_d) begin
      char_count_q <= char_count_q + 8'd1;
    end
  end

  assign bus.char_count = char_count_q;
`endif

endmodule

// File: tb/tb_ascii_serial_tx.sv
// Directed + randomized bench for ascii_serial_tx: a GAP_BITS=1 and a GAP_BITS=0 instance,
// strobed bits collected into queues and compared against characters expanded MSB-first plus gap ones.
module tb_ascii_serial_tx;
  import ascii_serial_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   qa[$];
  bit   qb[$];
  int   da = 0;
  int   db = 0;

  always #5 clk = ~clk;

  ascii_serial_tx_if #(.DATA_W(8)) ifa ();
  ascii_serial_tx_if #(.DATA_W(8)) ifb ();

  ascii_serial_tx #(.DATA_W(8), .GAP_BITS(1)) u_a (.CLOCK_50(clk), .RESET(rst), .bus(ifa.slave));
  ascii_serial_tx #(.DATA_W(8), .GAP_BITS(0)) u_b (.CLOCK_50(clk), .RESET(rst), .bus(ifb.slave));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, sample #1 after the edge and log every strobed bit and done pulse.
  task automatic step();
    @(posedge clk);
    #1;
    if (ifa.ser_strobe) qa.push_back(ifa.ser_out);
    if (ifa.done) da++;
    if (ifb.ser_strobe) qb.push_back(ifb.ser_out);
    if (ifb.done) db++;
  endtask

  task automatic drive(input bit b, input logic t, input logic lv, input logic [7:0] ch);
    if (b) begin
      ifb.bit_tick = t; ifb.load_valid = lv; ifb.char_in = ch;
    end else begin
      ifa.bit_tick = t; ifa.load_valid = lv; ifa.char_in = ch;
    end
  endtask

  function automatic logic [31:0] pack(input bit b, input int s, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) begin
      if (b) r = (s + i < qb.size()) ? {r[30:0], qb[s+i]} : {r[30:0], 1'bx};
      else   r = (s + i < qa.size()) ? {r[30:0], qa[s+i]} : {r[30:0], 1'bx};
    end
    return r;
  endfunction

  task automatic load(input bit b, input logic [7:0] ch, input string tag);
    int w = 0;
    while (!(b ? ifb.load_ready : ifa.load_ready) && w < 50) begin
      step();
      w++;
    end
    chk({tag, "_ready"}, 32'(b ? ifb.load_ready : ifa.load_ready), 32'd1);
    drive(b, 1'b0, 1'b1, ch);
    step();
    drive(b, 1'b0, 1'b0, 8'h00);
    chk({tag, "_busy"}, 32'(b ? ifb.busy : ifa.busy), 32'd1);
  endtask

  // mode 0: random ticks, otherwise one tick every 'mode' cycles; stops on the done pulse.
  task automatic run(input bit b, input int mode, input int maxc, input bit hold_ff,
                     output bit got, output bit lr_before);
    logic t;
    got = 1'b0;
    lr_before = 1'b0;
    for (int c = 0; c < maxc; c++) begin
      t = (mode == 0) ? ($urandom_range(0, 2) == 0) : ((c % mode) == mode - 1);
      lr_before = b ? ifb.load_ready : ifa.load_ready;
      drive(b, t, hold_ff, hold_ff ? 8'hFF : 8'h00);
      step();
      if (b ? ifb.done : ifa.done) begin
        got = 1'b1;
        break;
      end
    end
    drive(b, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    int  s, d0, nstr;
    bit  got, lrb;
    logic [7:0] ch;

    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    step();
    step();
    chk("rst_ser_out", 32'(ifa.ser_out), 32'd1);
    chk("rst_strobe", 32'(ifa.ser_strobe), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_ready", 32'(ifa.load_ready), 32'd1);
    chk("rst_b_ser_out", 32'(ifb.ser_out), 32'd1);
    chk("rst_b_busy", 32'(ifb.busy), 32'd0);
`ifdef ASCII_TX_CHAR_COUNT_EN
    chk("rst_char_count", 32'(ifa.char_count), 32'd0);
`endif
    drive(0, 1'b1, 1'b1, ASCII_E);
    step();
    chk("rst_beats_load", 32'(ifa.busy), 32'd0);
    drive(0, 1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    step();

    // 1: 'E' with a tick every 4 cycles
    s = qa.size(); d0 = da;
    load(0, ASCII_E, "t1");
    run(0, 4, 200, 1'b0, got, lrb);
    chk("t1_done_seen", 32'(got), 32'd1);
    chk("t1_nbits", 32'(qa.size() - s), 32'd9);
    chk("t1_bits", pack(0, s, 9), 32'({ASCII_E, 1'b1}));
    chk("t1_done_cnt", 32'(da - d0), 32'd1);
    chk("t1_idle_busy", 32'(ifa.busy), 32'd0);
    chk("t1_idle_ready", 32'(ifa.load_ready), 32'd1);
    step();
    chk("t1_done_1cyc", 32'(ifa.done), 32'd0);
    chk("t1_line_idle", 32'(ifa.ser_out), 32'd1);

    // 2: no gap, back-to-back 'E','A'
    s = qb.size();
    load(1, 8'h45, "t2a");
    run(1, 2, 200, 1'b0, got, lrb);
    chk("t2_done_a", 32'(got), 32'd1);
    chk("t2_ready_after", 32'(ifb.load_ready), 32'd1);
    chk("t2_ready_before", 32'(lrb), 32'd0);
    chk("t2_nbits_a", 32'(qb.size() - s), 32'd8);
    drive(1, 1'b0, 1'b1, 8'h41);
    step();
    drive(1, 1'b0, 1'b0, 8'h00);
    chk("t2b_busy", 32'(ifb.busy), 32'd1);
    run(1, 2, 200, 1'b0, got, lrb);
    chk("t2_done_b", 32'(got), 32'd1);
    chk("t2_nbits", 32'(qb.size() - s), 32'd16);
    chk("t2_bits", pack(1, s, 16), 32'h4541);

    // 3: 0xFF offered while busy is ignored
    s = qa.size();
    load(0, ASCII_E, "t3");
    run(0, 3, 200, 1'b1, got, lrb);
    chk("t3_done", 32'(got), 32'd1);
    chk("t3_nbits", 32'(qa.size() - s), 32'd9);
    chk("t3_bits", pack(0, s, 9), 32'({ASCII_E, 1'b1}));
    step();
    step();
    chk("t3_no_ff_load", 32'(ifa.busy), 32'd0);

    // 4: reset after the third strobed bit, with a tick in the same cycle
    d0 = da; nstr = 0;
    load(0, ASCII_E, "t4");
    for (int c = 0; c < 200 && nstr < 3; c++) begin
      drive(0, (c % 3) == 2, 1'b0, 8'h00);
      step();
      if (ifa.ser_strobe) nstr++;
    end
    chk("t4_reached3", 32'(nstr), 32'd3);
    drive(0, 1'b1, 1'b0, 8'h00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    chk("t4_ser_out", 32'(ifa.ser_out), 32'd1);
    chk("t4_busy", 32'(ifa.busy), 32'd0);
    chk("t4_ready", 32'(ifa.load_ready), 32'd1);
    chk("t4_strobe", 32'(ifa.ser_strobe), 32'd0);
    step();
    step();
    step();
    chk("t4_no_done", 32'(da - d0), 32'd0);
    s = qa.size();
    load(0, ASCII_E, "t4b");
    run(0, 2, 200, 1'b0, got, lrb);
    chk("t4_resend", pack(0, s, 9), 32'({ASCII_E, 1'b1}));
    chk("t4_resend_n", 32'(qa.size() - s), 32'd9);

    // 5: load and tick together: the tick is dropped
    s = qa.size();
    drive(0, 1'b1, 1'b1, ASCII_E);
    step();
    drive(0, 1'b0, 1'b0, 8'h00);
    chk("t5_no_strobe", 32'(ifa.ser_strobe), 32'd0);
    chk("t5_busy", 32'(ifa.busy), 32'd1);
    step();
    chk("t5_no_strobe2", 32'(qa.size() - s), 32'd0);
    run(0, 2, 200, 1'b0, got, lrb);
    chk("t5_bits", pack(0, s, 9), 32'({ASCII_E, 1'b1}));
    chk("t5_nbits", 32'(qa.size() - s), 32'd9);

    // random characters under random tick spacing
    for (int k = 0; k < 6; k++) begin
      ch = 8'($urandom);
      s = qa.size();
      load(0, ch, "rnd");
      run(0, 0, 500, 1'b0, got, lrb);
      chk("rnd_done", 32'(got), 32'd1);
      chk("rnd_nbits", 32'(qa.size() - s), 32'd9);
      chk("rnd_bits", pack(0, s, 9), 32'({ch, 1'b1}));
    end

`ifdef ASCII_TX_CHAR_COUNT_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("cc_reset", 32'(ifa.char_count), 32'd0);
    for (int k = 0; k < 257; k++) begin
      load(0, 8'($urandom), "cc");
      run(0, 1, 40, 1'b0, got, lrb);
      if (!got) chk("cc_done", 32'(got), 32'd1);
    end
    chk("cc_257", 32'(ifa.char_count), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
